// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: frame sequencer and readout master for a small pixel array.
// Each START runs ERASE -> EXPOSE -> CONVERT (ramp count driven on DATA) ->
// TURN (bus turnaround) -> SELECT/OUTPUT per pixel on a valid/ready stream.
// Build macro GRAY_CODE_EN: drive the ramp count as Gray code and decode the
// sampled pixel code back to binary, so PIX_DATA is binary in both builds.
module pixel_readout_ctrl #(
  parameter int N_PIXELS       = 4,
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255,
  parameter int READ_SETTLE    = 2,
  localparam int IDX_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic                pix_reset_o,
  output logic                pix_erase_o,
  output logic                pix_expose_o,
  output logic                pix_convert_o,
  output logic [N_PIXELS-1:0] read_o,
  inout  wire  [7:0]          data_io,
  output logic [7:0]          pix_data_o,
  output logic [IDX_W-1:0]    pix_idx_o,
  output logic                pix_valid_o,
  input  logic                pix_ready_i,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int CNT_W = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_TURN    = 3'd4;
  localparam logic [2:0] S_SELECT  = 3'd5;
  localparam logic [2:0] S_OUTPUT  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pix_data_q, pix_data_d;
  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
  logic             frame_done_q, frame_done_d;

  logic [7:0]       conv_code;
  logic [7:0]       sample_bin;

`ifdef GRAY_CODE_EN
  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign conv_code  = cnt_q[7:0] ^ (cnt_q[7:0] >> 1);
  assign sample_bin = gray_to_bin(data_io);
`else
  assign conv_code  = cnt_q[7:0];
  assign sample_bin = data_io;
`endif

  // The bus is only ours during CONVERT; READ is always 0 then, so no contention.
  assign data_io = (state_q == S_CONVERT) ? conv_code : 8'hzz;

  assign pix_reset_o   = (state_q == S_ERASE);
  assign pix_erase_o   = (state_q == S_ERASE);
  assign pix_expose_o  = (state_q == S_EXPOSE);
  assign pix_convert_o = (state_q == S_CONVERT);
  assign read_o        = (state_q == S_SELECT) ? (N_PIXELS'(1) << idx_q) : '0;
  assign pix_valid_o   = (state_q == S_OUTPUT);
  assign pix_data_o    = pix_data_q;
  assign pix_idx_o     = pix_idx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_done_o  = frame_done_q;

  // Next-state logic: phase timing, pixel selection and output handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A START coinciding with the FRAME_DONE pulse belongs to the old frame.
        if (start_i && !frame_done_q) begin
          state_d = S_ERASE;
          cnt_d   = '0;
        end
      end
      S_ERASE: begin
        if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == CNT_W'(EXPOSE_CYCLES - 1)) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        if (cnt_q == CNT_W'(CONVERT_CYCLES - 1)) begin
          state_d = S_TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TURN: begin
        state_d = S_SELECT;
        idx_d   = '0;
        cnt_d   = '0;
      end
      S_SELECT: begin
        if (cnt_q == CNT_W'(READ_SETTLE - 1)) begin
          pix_data_d = sample_bin;
          pix_idx_d  = idx_q;
          state_d    = S_OUTPUT;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (pix_ready_i) begin
          if (idx_q == IDX_W'(N_PIXELS - 1)) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SELECT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any frame in progress at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb_pixel_readout_ctrl: directed bench for pixel_readout_ctrl with a simple
// 4-pixel array model sharing the DATA bus. A pullup makes an undriven bus read 8'hFF.
module tb_pixel_readout_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       pixReady;
  logic       pixReset;
  logic       pixErase;
  logic       pixExpose;
  logic       pixConvert;
  logic [3:0] readSel;
  wire  [7:0] dataBus;
  logic [7:0] pixData;
  logic [1:0] pixIdx;
  logic       pixValid;
  logic       busy;
  logic       frameDone;

  int checks = 0;
  int errors = 0;

  logic [7:0] arrayMem [4];
  logic       arrayEn;
  logic [7:0] arrayVal;

  always #5 clk = ~clk;

  pullup (dataBus);

  // Pixel array model: the selected pixel drives its stored code onto DATA.
  always_comb begin
    arrayEn  = 1'b0;
    arrayVal = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (readSel[i]) begin
        arrayEn  = 1'b1;
        arrayVal = arrayMem[i];
      end
    end
  end

  assign dataBus = arrayEn ? arrayVal : 8'hzz;

  pixel_readout_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (start),
    .pix_reset_o  (pixReset),
    .pix_erase_o  (pixErase),
    .pix_expose_o (pixExpose),
    .pix_convert_o(pixConvert),
    .read_o       (readSel),
    .data_io      (dataBus),
    .pix_data_o   (pixData),
    .pix_idx_o    (pixIdx),
    .pix_valid_o  (pixValid),
    .pix_ready_i  (pixReady),
    .busy_o       (busy),
    .frame_done_o (frameDone)
  );

  // Value expected on DATA for ramp count n.
  function automatic logic [7:0] busCode(input int n);
    logic [7:0] c;
    c = n[7:0];
`ifdef GRAY_CODE_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  // Value expected on PIX_DATA for a stored pixel code.
  function automatic logic [7:0] expPix(input logic [7:0] stored);
`ifdef GRAY_CODE_EN
    logic [7:0] b;
    b = stored;
    for (int s = 1; s < 8; s++) b = b ^ (stored >> s);
    return b;
`else
    return stored;
`endif
  endfunction

  function automatic logic sigOf(input int sel);
    case (sel)
      0:       return pixErase;
      1:       return pixExpose;
      default: return pixConvert;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic countHigh(input int sel, output int n);
    n = 0;
    while (sigOf(sel) && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // Start a frame and stop in the TURN cycle.
  task automatic runToTurn();
    int n;
    pulseStart();
    n = 0;
    while (!pixConvert && n < 1000) begin n++; tick(); end
    while (pixConvert && n < 2000) begin n++; tick(); end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("[TB] FAIL run_to_turn: timeout after %0d cycles, required < 2000", n);
    end
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!pixValid && n < 100) begin n++; tick(); end
    checks++;
    if (!pixValid) begin
      errors++;
      $display("[TB] FAIL %s: PIX_VALID never rose within %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    rstN     = 1'b0;
    start    = 1'b0;
    pixReady = 1'b0;
    tick();
    tick();
    checks++;
    if ({pixReset, pixErase, pixExpose, pixConvert, readSel, pixData, pixIdx,
         pixValid, busy, frameDone} !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0h, required 0",
               {pixReset, pixErase, pixExpose, pixConvert, readSel, pixData, pixIdx,
                pixValid, busy, frameDone});
    end
    checks++;
    if (dataBus !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL reset_bus_z: got %0h, required ff (undriven)", dataBus);
    end
    rstN = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy %0b, required 0", busy);
    end
  endtask

  task automatic test_frame_timing();
    int n;
    pixReady = 1'b1;
    pulseStart();
    checks++;
    if ({pixErase, pixReset, pixExpose, pixConvert} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL erase_entry: got %b, required 1100",
               {pixErase, pixReset, pixExpose, pixConvert});
    end
    countHigh(0, n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL erase_len: got %0d, required 5", n);
    end
    checks++;
    if ({pixErase, pixExpose, pixConvert} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL expose_entry: got %b, required 010", {pixErase, pixExpose, pixConvert});
    end
    countHigh(1, n);
    checks++;
    if (n != 255) begin
      errors++;
      $display("[TB] FAIL expose_len: got %0d, required 255", n);
    end
    checks++;
    if ({pixErase, pixExpose, pixConvert, readSel} !== 7'b001_0000) begin
      errors++;
      $display("[TB] FAIL convert_entry: got %b, required 0010000",
               {pixErase, pixExpose, pixConvert, readSel});
    end
    n = 0;
    while (pixConvert && n < 2000) begin
      checks++;
      if (dataBus !== busCode(n)) begin
        errors++;
        $display("[TB] FAIL convert_data[%0d]: got %0h, required %0h", n, dataBus, busCode(n));
      end
      n++;
      tick();
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("[TB] FAIL convert_len: got %0d, required 255", n);
    end
    checks++;
    if ({pixConvert, readSel, dataBus, busy} !== {1'b0, 4'b0000, 8'hFF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL turn_cycle: conv %0b read %b data %0h busy %0b, required 0 0000 ff 1",
               pixConvert, readSel, dataBus, busy);
    end
    tick();
    checks++;
    if (readSel !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL first_select: got %b, required 0001", readSel);
    end
  endtask

  // Continues the frame started by test_frame_timing from the first SELECT cycle.
  task automatic test_readout();
    int cyc;
    logic [3:0] expSel;
    for (int p = 0; p < 4; p++) begin
      expSel = 4'b0001 << p;
      cyc = 0;
      while (!pixValid && cyc < 50) begin
        checks++;
        if (readSel !== expSel) begin
          errors++;
          $display("[TB] FAIL read_onehot[%0d]: got %b, required %b", p, readSel, expSel);
        end
        cyc++;
        tick();
      end
      checks++;
      if (cyc != 2) begin
        errors++;
        $display("[TB] FAIL select_len[%0d]: got %0d, required 2", p, cyc);
      end
      checks++;
      if ({readSel, pixIdx, pixData} !== {4'b0000, p[1:0], expPix(arrayMem[p])}) begin
        errors++;
        $display("[TB] FAIL pixel_out[%0d]: read %b idx %0d data %0d, required 0000 %0d %0d",
                 p, readSel, pixIdx, pixData, p, expPix(arrayMem[p]));
      end
      tick();
    end
    checks++;
    if ({frameDone, busy, pixValid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL frame_done: done/busy/valid %b, required 100", {frameDone, busy, pixValid});
    end
    tick();
    checks++;
    if (frameDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_done_pulse: got %0b, required 0", frameDone);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] expData;
    pixReady = 1'b1;
    runToTurn();
    tick();
    waitValid("bp_pixel0");
    tick();
    pixReady = 1'b0;
    waitValid("bp_pixel1");
    expData = expPix(arrayMem[1]);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({pixValid, pixIdx, pixData, readSel} !== {1'b1, 2'd1, expData, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: valid %0b idx %0d data %0d read %b, required 1 1 %0d 0000",
                 k, pixValid, pixIdx, pixData, readSel, expData);
      end
      tick();
    end
    pixReady = 1'b1;
    tick();
    checks++;
    if ({pixValid, readSel} !== {1'b0, 4'b0100}) begin
      errors++;
      $display("[TB] FAIL after_accept: valid %0b read %b, required 0 0100", pixValid, readSel);
    end
    waitValid("bp_pixel2");
    tick();
    waitValid("bp_pixel3");
    tick();
    checks++;
    if (frameDone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_frame_done: got %0b, required 1", frameDone);
    end
    tick();
  endtask

  task automatic test_reset_mid_convert();
    int n;
    pulseStart();
    n = 0;
    while (!(pixConvert && dataBus === busCode(100)) && n < 1000) begin n++; tick(); end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("[TB] FAIL reach_count100: timeout after %0d cycles", n);
    end
    #1;
    rstN = 1'b0;
    #1;
    checks++;
    if ({pixReset, pixErase, pixExpose, pixConvert, readSel, pixValid, busy, frameDone,
         dataBus} !== {11'h0, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL async_abort: ctrl %b data %0h, required 00000000000 ff",
               {pixReset, pixErase, pixExpose, pixConvert, readSel, pixValid, busy, frameDone},
               dataBus);
    end
    tick();
    rstN = 1'b1;
    tick();
    pulseStart();
    checks++;
    if ({pixErase, pixExpose, pixConvert} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL restart_erase: got %b, required 100", {pixErase, pixExpose, pixConvert});
    end
    countHigh(0, n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL restart_erase_len: got %0d, required 5", n);
    end
    doReset();
  endtask

  task automatic test_start_ignored();
    int n;
    int doneCnt;
    bit pulsed;
    pixReady = 1'b1;
    pulseStart();
    countHigh(0, n);
    n = 0;
    while (pixExpose && n < 2000) begin
      start = (n == 10);
      n++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (n != 255) begin
      errors++;
      $display("[TB] FAIL ign_expose_len: got %0d, required 255", n);
    end
    countHigh(2, n);
    checks++;
    if (n != 255) begin
      errors++;
      $display("[TB] FAIL ign_convert_len: got %0d, required 255", n);
    end
    doneCnt = 0;
    pulsed  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      start = 1'b0;
      if (pixValid && pixIdx == 2'd2 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (frameDone) doneCnt++;
      tick();
    end
    start = 1'b0;
    checks++;
    if ({doneCnt[3:0], busy, pulsed} !== {4'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ign_single_done: done pulses %0d busy %0b pixel2 seen %0b, required 1 0 1",
               doneCnt, busy, pulsed);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    pixReady = 1'b1;
    runToTurn();
    n = 0;
    while (!frameDone && n < 100) begin n++; tick(); end
    checks++;
    if (!frameDone) begin
      errors++;
      $display("[TB] FAIL b2b_done: FRAME_DONE missing after %0d cycles", n);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_on_done: busy %0b, required 0", busy);
    end
    pulseStart();
    checks++;
    if ({busy, pixErase} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL start_after_done: busy/erase %b, required 11", {busy, pixErase});
    end
    doReset();
  endtask

`ifdef GRAY_CODE_EN
  task automatic test_gray();
    int n;
    logic [7:0] grayExp [4];
    grayExp[0] = 8'h00;
    grayExp[1] = 8'h01;
    grayExp[2] = 8'h03;
    grayExp[3] = 8'h02;
    arrayMem[0] = 8'hC0;
    pixReady = 1'b1;
    pulseStart();
    n = 0;
    while (!pixConvert && n < 1000) begin n++; tick(); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dataBus !== grayExp[k]) begin
        errors++;
        $display("[TB] FAIL gray_bus[%0d]: got %0h, required %0h", k, dataBus, grayExp[k]);
      end
      tick();
    end
    n = 0;
    while (!pixValid && n < 1000) begin n++; tick(); end
    checks++;
    if ({pixIdx, pixData} !== {2'd0, 8'd128}) begin
      errors++;
      $display("[TB] FAIL gray_decode: idx %0d data %0d, required 0 128", pixIdx, pixData);
    end
    doReset();
    arrayMem[0] = 8'd3;
  endtask
`endif

  initial begin
    arrayMem[0] = 8'd3;
    arrayMem[1] = 8'd127;
    arrayMem[2] = 8'd153;
    arrayMem[3] = 8'd3;
    test_reset();
    test_frame_timing();
    test_readout();
    test_backpressure();
    test_reset_mid_convert();
    test_start_ignored();
    test_back_to_back();
`ifdef GRAY_CODE_EN
    test_gray();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
- Frame sequencer and readout master for the 4-pixel array; the driving end of the array's shared DATA bus.
- Runs one frame per START: pixel erase, exposure, then conversion, during which it drives the digital ramp count onto DATA.
- Then selects each pixel in turn with one-hot READ, samples the stored code from DATA, and emits it on a valid/ready stream.
- Sits between the system controller and the pixel array. The analog RAMP source is external and is gated by PIX_CONVERT.

Parameters:
- N_PIXELS, 4, number of pixels; width of READ and range of PIX_IDX.
- ERASE_CYCLES, 5, cycles PIX_ERASE and PIX_RESET are held high.
- EXPOSE_CYCLES, 255, cycles PIX_EXPOSE is held high.
- CONVERT_CYCLES, 255, cycles PIX_CONVERT is held high and the count is driven; range 1..256.
- READ_SETTLE, 2, cycles READ[i] is held before DATA is sampled; minimum 1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle frame request; accepted only in IDLE.
- PIX_RESET  out  1  to the array RESET input.
- PIX_ERASE  out  1  to the array ERASE input.
- PIX_EXPOSE  out  1  to the array EXPOSE input.
- PIX_CONVERT  out  1  to the array CONVERT input.
- READ  out  N_PIXELS  one-hot pixel select to the array READ input.
- DATA  inout  8  shared bus; driven only in CONVERT, otherwise high-Z.
- PIX_DATA  out  8  sampled pixel code.
- PIX_IDX  out  clog2(N_PIXELS)  index of the pixel on PIX_DATA.
- PIX_VALID  out  1  PIX_DATA and PIX_IDX are valid.
- PIX_READY  in  1  downstream accepts the current pixel.
- BUSY  out  1  high whenever the state is not IDLE.
- FRAME_DONE  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset values (RESET low, asynchronous): every output low, READ = 0, DATA high-Z, state IDLE, all counters 0. Asserting RESET mid-frame aborts the frame immediately, with no partial output.
- IDLE -> ERASE on START = 1. START in any other state is ignored; no queueing.
- ERASE: PIX_ERASE = PIX_RESET = 1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: PIX_EXPOSE = 1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT: PIX_CONVERT = 1 for exactly CONVERT_CYCLES cycles.
  - 8-bit count starts at 0 in the first CONVERT cycle and increments by 1 each cycle.
  - The last value driven is CONVERT_CYCLES-1. No wrap is possible within the legal range.
  - DATA is driven with the count in the same cycles PIX_CONVERT is high, and only then.
- TURN: one idle cycle with DATA at high-Z, PIX_CONVERT low and READ = 0 (bus turnaround). Pixel index is set to 0.
- SELECT: READ = 1<<idx for READ_SETTLE cycles.
  - On the last SELECT cycle, the registered sample of DATA loads PIX_DATA, and idx loads PIX_IDX.
  - Next cycle: READ = 0, PIX_VALID = 1, state OUTPUT.
- OUTPUT: PIX_VALID, PIX_DATA and PIX_IDX stay stable until the cycle with PIX_VALID & PIX_READY.
  - If idx < N_PIXELS-1: idx increments, go to SELECT.
  - Else: FRAME_DONE pulses for 1 cycle, go to IDLE.
  - PIX_VALID drops the cycle after acceptance.
- Backpressure: PIX_READY low holds OUTPUT indefinitely; READ stays 0 while stalled.
- PIX_READY held high gives a per-pixel cost of READ_SETTLE+1 cycles.
- Bus rule (invariant): the block never drives DATA in a cycle where any READ bit is 1.
- A START arriving in the same cycle as FRAME_DONE is ignored. START in the cycle after FRAME_DONE, with the state in IDLE, is accepted.
- Exactly one of PIX_ERASE, PIX_EXPOSE and PIX_CONVERT is high at a time, or none.

Optional Feature:
- GRAY_CODE_EN defined:
  - The CONVERT count is driven on DATA as Gray code, count ^ (count >> 1).
  - The sampled value is Gray-to-binary decoded before loading PIX_DATA, so PIX_DATA is binary in both builds.
  - Decode adds no cycle of latency.
- GRAY_CODE_EN undefined:
  - Plain binary is driven on DATA.
  - PIX_DATA equals the raw sample.

Test Plan:
- Frame timing: with defaults, START pulse.
  - PIX_ERASE high 5 cycles, PIX_EXPOSE high 255, PIX_CONVERT high 255.
  - DATA goes 0..254 (binary build), then high-Z for one TURN cycle before READ = 4'b0001.
- Readout: array model stores 8'd3, 8'd127, 8'd153, 8'd3 with PIX_READY held 1.
  - Four handshakes with PIX_IDX 0,1,2,3 and matching PIX_DATA.
  - READ is one-hot for each pixel in turn, then FRAME_DONE pulses once and BUSY falls.
- Backpressure: hold PIX_READY = 0 for 20 cycles on pixel 1.
  - PIX_VALID, PIX_DATA and PIX_IDX stay constant and READ = 0 throughout.
  - Pixel 2 is selected only after acceptance.
- Reset mid-CONVERT: pull RESET low at count 100.
  - All outputs 0, DATA high-Z, with no clock edge needed.
  - After release, the next START restarts from ERASE.
- START ignored: pulse START during EXPOSE and during OUTPUT.
  - No change to sequence or counts; exactly one FRAME_DONE.
- GRAY_CODE_EN build:
  - DATA shows 8'h00, 8'h01, 8'h03, 8'h02 in the first four CONVERT cycles.
  - A pixel latching Gray code 8'hC0 yields PIX_DATA = 8'd128.
